// File: rtl/deserializer.sv
// deserializer: rebuilds MSB-first serial bursts into left-aligned parallel words.
// A full word is emitted as soon as its WIDTH-th bit arrives. A burst remainder is
// emitted when valid falls, or reported on runt_o if it is shorter than MIN_BITS.
module deserializer #(
    parameter int WIDTH    = 16,
    parameter int MIN_BITS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   ser_data_i,
    input  logic                   ser_data_val_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(WIDTH):0] data_mod_o,
    output logic                   data_val_o,
    output logic                   runt_o
);
    // state | meaning
    // IDLE  | no partial word held, bit count 0
    // RECV  | partial word of 1..WIDTH-1 bits held in the assembly register

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(WIDTH);
    localparam logic [CW-1:0]    MIN_CNT  = CW'(MIN_BITS);
    localparam logic [WIDTH-1:0] MSB_ONE  = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  asm_q, asm_d;
    logic [WIDTH-1:0]  data_d;
    logic [CW-1:0]     mod_d;
    logic              val_d, runt_d;

    logic [CW-1:0]     base_cnt, cnt_inc;
    logic [WIDTH-1:0]  base_asm, bit_vec;

    // next-state, assembly and output-register logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        data_d   = data_o;
        mod_d    = data_mod_o;
        val_d    = 1'b0;
        runt_d   = 1'b0;

        // a word starting in IDLE begins from a cleared register, so unused LSBs stay 0
        base_cnt = (state_q == IDLE) ? '0 : cnt_q;
        base_asm = (state_q == IDLE) ? '0 : asm_q;
        cnt_inc  = base_cnt + CW'(1);
        bit_vec  = ser_data_i ? (MSB_ONE >> base_cnt) : '0;

        if (ser_data_val_i) begin
            if (cnt_inc == FULL_CNT) begin
                // full word: emit now so a continuing burst starts the next word without a gap
                data_d  = base_asm | bit_vec;
                mod_d   = FULL_CNT;
                val_d   = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
                asm_d   = '0;
            end else begin
                state_d = RECV;
                cnt_d   = cnt_inc;
                asm_d   = base_asm | bit_vec;
            end
        end else if (state_q == RECV) begin
            if (cnt_q >= MIN_CNT) begin
                data_d = asm_q;
                mod_d  = cnt_q;
                val_d  = 1'b1;
            end else begin
                runt_d = 1'b1;
            end
            state_d = IDLE;
            cnt_d   = '0;
            asm_d   = '0;
        end
    end

    // state, bit count and assembly register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
        end
    end

    // registered outputs; data/mod hold between strobes
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o     <= '0;
            data_mod_o <= '0;
            data_val_o <= 1'b0;
            runt_o     <= 1'b0;
        end else begin
            data_o     <= data_d;
            data_mod_o <= mod_d;
            data_val_o <= val_d;
            runt_o     <= runt_d;
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: table vectors, hand-written corner sequences and random bursts
// checked against a burst-chunking reference model.
module tb_deserializer;
    localparam int WIDTH    = 16;
    localparam int MIN_BITS = 4;
    localparam int MW       = $clog2(WIDTH) + 1;
    localparam int OBS_MAX  = 2048;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             ser_data_i;
    logic             ser_data_val_i;
    logic [WIDTH-1:0] data_o;
    logic [MW-1:0]    data_mod_o;
    logic             data_val_o;
    logic             runt_o;

    deserializer #(.WIDTH(WIDTH), .MIN_BITS(MIN_BITS)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .ser_data_i     (ser_data_i),
        .ser_data_val_i (ser_data_val_i),
        .data_o         (data_o),
        .data_mod_o     (data_mod_o),
        .data_val_o     (data_val_o),
        .runt_o         (runt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit               runt;
        logic [WIDTH-1:0] data;
        int               mod;
    } ev_t;

    typedef struct {
        logic [31:0] pat;
        int          len;
        int          nval;
        int          nrunt;
        logic [15:0] data;
        int          mod;
    } vec_t;

    ev_t exp_q[$];
    bit  stim[$];
    logic [WIDTH-1:0] model_last_data = '0;
    int               model_last_mod  = 0;

    // strobe log, written only by the monitor
    logic [1:0]       obs_kind [OBS_MAX];
    logic [WIDTH-1:0] obs_data [OBS_MAX];
    logic [MW-1:0]    obs_mod  [OBS_MAX];
    int obs_wr = 0;
    int obs_rd = 0;
    int n_val  = 0;
    int n_runt = 0;

    // record every strobe cycle away from the active edge
    always @(negedge clk_i) begin
        if (data_val_o || runt_o) begin
            if (obs_wr < OBS_MAX) begin
                obs_kind[obs_wr] <= {data_val_o, runt_o};
                obs_data[obs_wr] <= data_o;
                obs_mod[obs_wr]  <= data_mod_o;
                obs_wr           <= obs_wr + 1;
            end
            if (data_val_o) n_val  <= n_val + 1;
            if (runt_o)     n_runt <= n_runt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic cycle(input logic v, input logic d);
        ser_data_val_i = v;
        ser_data_i     = d;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic load(input logic [31:0] p, input int len);
        stim.delete();
        for (int k = 0; k < len; k++) stim.push_back(p[31-k]);
    endtask

    // reference: split the burst into WIDTH-bit chunks; full chunks and long remainders
    // become words, short remainders become runts
    task automatic push_expect();
        int len;
        len = stim.size();
        for (int i = 0; i < len; i += WIDTH) begin
            int  n;
            int  acc;
            ev_t e;
            n   = (len - i < WIDTH) ? (len - i) : WIDTH;
            acc = 0;
            for (int k = 0; k < n; k++)
                if (stim[i+k]) acc += 2 ** (WIDTH - 1 - k);
            e.data = acc[WIDTH-1:0];
            e.mod  = n;
            e.runt = (n < MIN_BITS);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_stim(input int gap);
        push_expect();
        foreach (stim[k]) cycle(1'b1, stim[k]);
        idle(gap);
    endtask

    task automatic drain();
        while (obs_rd < obs_wr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'(obs_kind[obs_rd]), 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.runt) begin
                    chk("runt_kind", 32'(obs_kind[obs_rd]), 32'b01);
                    chk("runt_hold_data", 32'(obs_data[obs_rd]), 32'(model_last_data));
                    chk("runt_hold_mod", 32'(obs_mod[obs_rd]), 32'(model_last_mod));
                end else begin
                    chk("word_kind", 32'(obs_kind[obs_rd]), 32'b10);
                    chk("word_data", 32'(obs_data[obs_rd]), 32'(e.data));
                    chk("word_mod", 32'(obs_mod[obs_rd]), 32'(e.mod));
                    model_last_data = e.data;
                    model_last_mod  = e.mod;
                end
            end
            obs_rd++;
        end
    endtask

    task automatic check_empty(input string name);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    vec_t tbl[8];

    initial begin
        int v0, r0;

        tbl[0] = '{32'hA500_0000,  8, 1, 0, 16'hA500,  8};
        tbl[1] = '{32'hBEEF_0000, 16, 1, 0, 16'hBEEF, 16};
        tbl[2] = '{32'h1234_C000, 20, 2, 0, 16'hC000,  4};
        tbl[3] = '{32'hE000_0000,  3, 0, 1, 16'hC000,  4};
        tbl[4] = '{32'h9000_0000,  4, 1, 0, 16'h9000,  4};
        tbl[5] = '{32'hDEAD_BEEF, 32, 2, 0, 16'hBEEF, 16};
        tbl[6] = '{32'hFFFF_8000, 17, 1, 1, 16'hFFFF, 16};
        tbl[7] = '{32'h0000_0000,  1, 0, 1, 16'hFFFF, 16};

        rst_n_i        = 1'b0;
        ser_data_i     = 1'b0;
        ser_data_val_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_data", 32'(data_o), 32'd0);
        chk("reset_mod", 32'(data_mod_o), 32'd0);
        chk("reset_val", 32'(data_val_o), 32'd0);
        chk("reset_runt", 32'(runt_o), 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        foreach (tbl[i]) begin
            v0 = n_val;
            r0 = n_runt;
            load(tbl[i].pat, tbl[i].len);
            send_stim(3);
            chk($sformatf("tbl%0d_nval", i), 32'(n_val - v0), 32'(tbl[i].nval));
            chk($sformatf("tbl%0d_nrunt", i), 32'(n_runt - r0), 32'(tbl[i].nrunt));
            chk($sformatf("tbl%0d_data", i), 32'(data_o), 32'(tbl[i].data));
            chk($sformatf("tbl%0d_mod", i), 32'(data_mod_o), 32'(tbl[i].mod));
        end
        drain();
        check_empty("tbl_missing_strobes");

        // full-word latency and single-cycle strobe, no tail strobe
        load(32'hBEEF_0000, 16);
        push_expect();
        for (int k = 0; k < 15; k++) cycle(1'b1, stim[k]);
        chk("fw_no_early_val", 32'(data_val_o), 32'd0);
        cycle(1'b1, stim[15]);
        chk("fw_val_next_cycle", 32'(data_val_o), 32'd1);
        chk("fw_data", 32'(data_o), 32'hBEEF);
        cycle(1'b0, 1'b0);
        chk("fw_val_one_cycle", 32'(data_val_o), 32'd0);
        chk("fw_no_tail_runt", 32'(runt_o), 32'd0);
        idle(2);
        drain();
        check_empty("fw_missing_strobes");

        // back-to-back bursts separated by a single low cycle
        load(32'h8800_0000, 5);
        send_stim(1);
        load(32'hB400_0000, 6);
        send_stim(1);
        load(32'h4000_0000, 2);
        send_stim(3);
        drain();
        check_empty("b2b_missing_strobes");

        // asynchronous reset mid-burst discards the partial word
        load(32'hB400_0000, 6);
        foreach (stim[k]) cycle(1'b1, stim[k]);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("async_rst_data", 32'(data_o), 32'd0);
        chk("async_rst_mod", 32'(data_mod_o), 32'd0);
        chk("async_rst_val", 32'(data_val_o), 32'd0);
        chk("async_rst_runt", 32'(runt_o), 32'd0);
        model_last_data = '0;
        model_last_mod  = 0;
        ser_data_val_i  = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        load(32'h8800_0000, 5);
        send_stim(3);
        chk("post_rst_data", 32'(data_o), 32'h8800);
        chk("post_rst_mod", 32'(data_mod_o), 32'd5);
        drain();
        check_empty("rst_missing_strobes");

        // reset released while valid is high: the rest of the burst is a new burst
        ser_data_val_i = 1'b1;
        ser_data_i     = 1'b1;
        rst_n_i        = 1'b0;
        @(negedge clk_i);
        model_last_data = '0;
        model_last_mod  = 0;
        load(32'hB000_0000, 5);
        push_expect();
        rst_n_i = 1'b1;
        @(negedge clk_i);
        for (int k = 1; k < 5; k++) cycle(1'b1, stim[k]);
        idle(3);
        drain();
        check_empty("rel_missing_strobes");

        // loopback-style traffic: random words of 4..15 bits, short random gaps
        r0 = n_runt;
        for (int w = 0; w < 100; w++) begin
            int          m;
            logic [31:0] word;
            m    = $urandom_range(4, 15);
            word = $urandom;
            load({word[15:0], 16'h0000}, m);
            send_stim($urandom_range(1, 3));
        end
        idle(2);
        chk("loop_no_runt", 32'(n_runt - r0), 32'd0);
        drain();
        check_empty("loop_missing_strobes");

        // random burst lengths spanning runts, full words and remainders
        for (int b = 0; b < 80; b++) begin
            int len;
            len = $urandom_range(1, 40);
            stim.delete();
            for (int k = 0; k < len; k++) stim.push_back(1'($urandom_range(0, 1)));
            send_stim($urandom_range(1, 3));
        end
        idle(2);
        drain();
        check_empty("rand_missing_strobes");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
